delay_sched: RTL and testbench
==============================

Name: delay_sched

Overview:
- Shares one CBITS-wide delay counter between NREQ requesters.
- Each requester asks for a programmable delay. A round-robin arbiter grants the counter, which counts the granted delay; the block then returns a one-cycle done pulse to the winner.
- Sits between the control FSMs that need timed waits and the shared delay counter. It provides the counter's sequencing and its err/flg safety monitors.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CBITS, 19, counter and delay width.
- MAXDLY, 400000, largest legal delay. Larger requests are clamped to MAXDLY.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req  input  NREQ  per-requester request level. Must be held until done, otherwise the request aborts.
- req_dly  input  NREQ*CBITS  per-requester delay; slice i is bits [i*CBITS +: CBITS].
- gnt  output  NREQ  one-hot grant, held from grant through the done cycle.
- done  output  NREQ  one-hot, one-cycle pulse when the granted delay expires.
- busy  output  1  1 when state is not IDLE.
- cnt_o  output  CBITS  current counter value.
- err  output  1  sticky; counter exceeded the latched limit.
- flg  output  1  registered in-range indicator, equal to (cnt <= lim).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, lim=0, rr pointer=0.
  - gnt=0, done=0, busy=0, err=0, flg=1.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit scanning from the rr pointer upward, modulo NREQ. Call it w.
  - At that edge: gnt=onehot(w), lim=min(req_dly[w], MAXDLY), cnt=0, state=COUNT.
  - If no req bit is set, stay in IDLE with cnt=0.
- COUNT:
  - If req[w]=0 (abort): go to IDLE. gnt=0, cnt=0, no done pulse, rr pointer=w+1 mod NREQ.
  - Else if cnt==lim: state=DONE, done[w]=1.
  - Else: cnt=cnt+1, with CBITS-bit arithmetic.
- DONE:
  - done is high for exactly this one cycle and gnt is still high.
  - At the next edge: done=0, gnt=0, cnt=0, rr pointer=w+1 mod NREQ, state=IDLE.
  - A new grant is never issued from DONE, so there is always at least one IDLE cycle between grants.
- Latency:
  - req is first sampled high at edge k. Grant is visible after edge k.
  - done is visible after edge k+lim+1 and drops after edge k+lim+2.
  - lim=0 gives done after edge k+1.
- Fairness: a requester holding req is granted within NREQ-1 other services.
- Simultaneous requests: priority is decided by the rr pointer only; req_dly of the losers is ignored.
- req_dly changing during COUNT has no effect, because lim is latched at grant.
- err:
  - Set to 1 at any edge where cnt > lim (registered compare). Cleared only by reset.
  - This condition is unreachable by design and is a formal safety target.
- flg: updated every edge to (next cnt <= next lim). It is 1 in normal operation.
- cnt never exceeds MAXDLY, so it never wraps.
- Reset mid-COUNT or mid-DONE: everything returns to reset values immediately. No done pulse is produced.

Test Plan:
- Single request: req[0]=1, req_dly[0]=5 → gnt[0] after edge 1; done[0] pulses after edge 7; busy falls after edge 8; err=0 and flg=1 throughout.
- Zero delay: req[2]=1, dly=0 → done[2] one cycle after grant; cnt_o stays 0.
- Round robin: req=4'b1111, all dly=2 → grants in order 0,1,2,3,0; each done is separated by one IDLE cycle.
- Abort: req[1]=1, dly=10, req[1] dropped at cnt=4 → IDLE next edge, no done pulse; a pending req[3] is granted next.
- Clamp and max: dly=0x7FFFF → lim=400000; done after 400001 counting cycles; err=0.
- Async reset: assert rst=0 mid-COUNT at cnt=3 → all outputs at reset values without waiting for a clock edge; after release, a pending req is re-granted starting from requester 0.

Source files
------------

// File: rtl/delay_sched.sv
// rtl/delay_sched.sv - round-robin shared delay counter with per-requester done pulses
// One counter serves NREQ requesters; err/flg monitor the counter against the latched limit.
module delay_sched #(
   parameter int NREQ   = 4,
   parameter int CBITS  = 19,
   parameter int MAXDLY = 400000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*CBITS-1:0]   req_dly,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic                    busy,
   output logic [CBITS-1:0]        cnt_o,
   output logic                    err,
   output logic                    flg
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CBITS-1:0] MAXV = CBITS'(MAXDLY);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t           state, state_nx;
   logic [IW-1:0]    w, w_nx, rr, rr_nx, pick, w_inc;
   logic [CBITS-1:0] cnt, cnt_nx, lim, lim_nx, pick_dly;
   logic [NREQ-1:0]  w_hot;
   logic             found;

   // Scan from the rr pointer upward, wrapping modulo NREQ; first set bit wins.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(rr) + i) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   assign pick_dly = req_dly[int'(pick)*CBITS +: CBITS];
   assign w_inc    = (int'(w) == NREQ-1) ? '0 : w + 1'b1;
   assign w_hot    = {{(NREQ-1){1'b0}}, 1'b1} << w;

   always_comb begin
      state_nx = state;
      w_nx     = w;
      rr_nx    = rr;
      cnt_nx   = cnt;
      lim_nx   = lim;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (found) begin
               state_nx = COUNT;
               w_nx     = pick;
               lim_nx   = (pick_dly > MAXV) ? MAXV : pick_dly;
            end
         end
         COUNT: begin
            if (!req[w]) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               rr_nx    = w_inc;
            end else if (cnt == lim) begin
               state_nx = DONE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            rr_nx    = w_inc;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         w     <= '0;
         rr    <= '0;
         cnt   <= '0;
         lim   <= '0;
         err   <= 1'b0;
         flg   <= 1'b1;
      end else begin
         state <= state_nx;
         w     <= w_nx;
         rr    <= rr_nx;
         cnt   <= cnt_nx;
         lim   <= lim_nx;
         err   <= err | (cnt > lim);
         flg   <= (cnt_nx <= lim_nx);
      end
   end

   assign gnt   = (state != IDLE) ? w_hot : '0;
   assign done  = (state == DONE) ? w_hot : '0;
   assign busy  = (state != IDLE);
   assign cnt_o = cnt;

endmodule

// File: tb/tb_delay_sched.sv
// tb/tb_delay_sched.sv - directed table-driven bench for delay_sched
// MAXDLY is reduced so clamp behaviour is reachable in a short run.
module tb_delay_sched;

   localparam int NREQ   = 4;
   localparam int CBITS  = 19;
   localparam int MAXDLY = 37;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*CBITS-1:0] req_dly;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic [CBITS-1:0]      cnt_o;
   logic                  err;
   logic                  flg;

   delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .MAXDLY(MAXDLY)) dut (
      .clk(clk), .rst(rst), .req(req), .req_dly(req_dly),
      .gnt(gnt), .done(done), .busy(busy), .cnt_o(cnt_o),
      .err(err), .flg(flg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0]       rq;
      logic [NREQ*CBITS-1:0] dly;
      int                    w;
      int                    lim;
   } vec_t;

   vec_t tbl [13];
   int   checks = 0;
   int   errors = 0;
   bit   err_seen = 0;
   bit   flg_low = 0;

   function automatic logic [NREQ*CBITS-1:0] pk(input int a, input int b, input int c, input int d);
      return {CBITS'(d), CBITS'(c), CBITS'(b), CBITS'(a)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (err) err_seen = 1;
         if (!flg) flg_low = 1;
      end
   end

   initial begin
      int n;
      tbl[0]  = '{4'b0001, pk(5, 0, 0, 0),          0, 5};
      tbl[1]  = '{4'b0100, pk(0, 0, 0, 0),          2, 0};
      tbl[2]  = '{4'b1111, pk(2, 2, 2, 2),          3, 2};
      tbl[3]  = '{4'b1111, pk(2, 2, 2, 2),          0, 2};
      tbl[4]  = '{4'b1111, pk(2, 2, 2, 2),          1, 2};
      tbl[5]  = '{4'b1111, pk(2, 2, 2, 2),          2, 2};
      tbl[6]  = '{4'b1111, pk(2, 2, 2, 2),          3, 2};
      tbl[7]  = '{4'b1010, pk(0, 3, 0, 9),          1, 3};
      tbl[8]  = '{4'b1010, pk(0, 3, 0, 9),          3, 9};
      tbl[9]  = '{4'b0001, pk(19'h7FFFF, 0, 0, 0),  0, MAXDLY};
      tbl[10] = '{4'b0001, pk(MAXDLY, 0, 0, 0),     0, MAXDLY};
      tbl[11] = '{4'b0001, pk(MAXDLY+1, 0, 0, 0),   0, MAXDLY};
      tbl[12] = '{4'b1000, pk(0, 0, 0, 1),          3, 1};

      rst = 1'b0;
      req = '0;
      req_dly = '0;
      #12;
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", cnt_o, 0);
      chk("rst_err", err, 0);
      chk("rst_flg", flg, 1);
      rst = 1'b1;
      step();

      for (int v = 0; v < 13; v++) begin
         req = tbl[v].rq;
         req_dly = tbl[v].dly;
         step();
         chk($sformatf("v%0d_gnt", v), gnt, 32'(1) << tbl[v].w);
         chk($sformatf("v%0d_busy", v), busy, 1);
         chk($sformatf("v%0d_cnt0", v), cnt_o, 0);
         n = 0;
         while (done == 0 && n < 64) begin
            step();
            n++;
         end
         chk($sformatf("v%0d_latency", v), n, tbl[v].lim + 1);
         chk($sformatf("v%0d_done", v), done, 32'(1) << tbl[v].w);
         chk($sformatf("v%0d_gnt_at_done", v), gnt, 32'(1) << tbl[v].w);
         chk($sformatf("v%0d_cnt_at_done", v), cnt_o, tbl[v].lim);
         req = '0;
         step();
         chk($sformatf("v%0d_idle_busy", v), busy, 0);
         chk($sformatf("v%0d_idle_out", v), {gnt, done}, 0);
      end

      // Held requests: grants rotate 0,1,2,3,0 with one IDLE cycle between services.
      req = 4'b1111;
      req_dly = pk(2, 2, 2, 2);
      for (int s = 0; s < 5; s++) begin
         step();
         chk($sformatf("rr%0d_gnt", s), gnt, 32'(1) << (s % 4));
         step();
         step();
         chk($sformatf("rr%0d_cnt", s), cnt_o, 2);
         chk($sformatf("rr%0d_nodone", s), done, 0);
         step();
         chk($sformatf("rr%0d_done", s), done, 32'(1) << (s % 4));
         step();
         chk($sformatf("rr%0d_gap", s), {busy, gnt, done}, 0);
      end
      req = '0;
      step();

      // Abort: drop req[1] at cnt=4; pending req[3] is served next.
      req = 4'b1010;
      req_dly = pk(0, 10, 0, 4);
      step();
      chk("ab_gnt", gnt, 4'b0010);
      repeat (4) step();
      chk("ab_cnt4", cnt_o, 4);
      req = 4'b1000;
      step();
      chk("ab_idle", {busy, gnt, done}, 0);
      chk("ab_cnt_clr", cnt_o, 0);
      step();
      chk("ab_next_gnt", gnt, 4'b1000);
      n = 0;
      while (done == 0 && n < 64) begin
         step();
         n++;
      end
      chk("ab_next_latency", n, 5);
      chk("ab_next_done", done, 4'b1000);
      req = '0;
      step();

      // Async reset mid-COUNT; rr pointer must return to 0.
      req = 4'b0001;
      req_dly = pk(0, 0, 0, 0);
      step();
      step();
      req = '0;
      step();
      req = 4'b0101;
      req_dly = pk(6, 0, 8, 0);
      step();
      chk("rs_gnt_pre", gnt, 4'b0100);
      repeat (3) step();
      chk("rs_cnt3", cnt_o, 3);
      #1;
      rst = 1'b0;
      #1;
      chk("rs_async", {busy, gnt, done}, 0);
      chk("rs_async_cnt", cnt_o, 0);
      chk("rs_async_flg", flg, 1);
      #1;
      rst = 1'b1;
      step();
      chk("rs_regrant", gnt, 4'b0001);
      n = 0;
      while (done == 0 && n < 64) begin
         step();
         n++;
      end
      chk("rs_latency", n, 7);
      req = '0;
      step();

      chk("err_never", err_seen, 0);
      chk("flg_always", flg_low, 0);
      chk("err_final", err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
